// File: rtl/riscy_pkg.sv
// Shared widths, opcode/sub-op encodings and FSM states for the riscy_cpu core.
// RISCY_HALT_EN (see riscy_cpu) decides whether HALTED is ever reachable.
package riscy_pkg;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    typedef enum logic [2:0] {
        OP_SYS = 3'd0,
        OP_LD  = 3'd1,
        OP_ST  = 3'd2,
        OP_ADD = 3'd3,
        OP_SUB = 3'd4,
        OP_AND = 3'd5,
        OP_JMP = 3'd6,
        OP_JZ  = 3'd7
    } opcode_e;

    localparam logic [ADDR_W-1:0] SYS_NOP  = 5'h00;
    localparam logic [ADDR_W-1:0] SYS_IN   = 5'h01;
    localparam logic [ADDR_W-1:0] SYS_OUT  = 5'h02;
    localparam logic [ADDR_W-1:0] SYS_HALT = 5'h1f;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        HALTED = 2'd2
    } state_e;
endpackage

// File: rtl/riscy_rom32.sv
// 32x8 program ROM with combinational read; contents are loaded from outside
// through the hierarchical array `memory`, the core never writes it.
module riscy_rom32
    import riscy_pkg::*;
(
    input  logic [ADDR_W-1:0] addr_i,
    output logic [DATA_W-1:0] data_o
);
    logic [DATA_W-1:0] memory [0:DEPTH-1];

    assign data_o = memory[addr_i];
endmodule

// File: rtl/riscy_cpu.sv
// 8-bit accumulator core: two-cycle FETCH/EXEC FSM, 32x8 RAM, tristate I/O port.
// Define RISCY_HALT_EN to make SYS 11111 stop the core until reset.
module riscy_cpu
    import riscy_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    inout  wire  [DATA_W-1:0] IO
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] oreg_q, oreg_d;
    logic              c_q, c_d;
    logic              z_q, z_d;

    logic [DATA_W-1:0] ram [0:DEPTH-1];
    logic              ram_we;
    logic [DATA_W-1:0] rom_data;
    logic              PORT_RD;

    opcode_e           op;
    logic [ADDR_W-1:0] operand;
    logic [DATA_W-1:0] mem;
    logic [DATA_W:0]   sum, diff;

    riscy_rom32 ROM32 (
        .addr_i (pc_q),
        .data_o (rom_data)
    );

    assign op      = opcode_e'(ir_q[7:5]);
    assign operand = ir_q[4:0];
    assign mem     = ram[operand];
    assign sum     = {1'b0, acc_q} + {1'b0, mem};
    // Bit 8 of the 9-bit difference is the borrow out.
    assign diff    = {1'b0, acc_q} - {1'b0, mem};

    // Kept outside the next-state block so the IO read below has no comb loop.
    assign PORT_RD = (state_q == EXEC) && (ir_q == {OP_SYS, SYS_IN});
    assign IO      = PORT_RD ? {DATA_W{1'bz}} : oreg_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        acc_d   = acc_q;
        oreg_d  = oreg_q;
        c_d     = c_q;
        z_d     = z_q;
        ram_we  = 1'b0;
        case (state_q)
            FETCH: begin
                ir_d    = rom_data;
                pc_d    = pc_q + 5'd1;
                state_d = EXEC;
            end
            EXEC: begin
                state_d = FETCH;
                case (op)
                    OP_SYS: begin
                        case (operand)
                            SYS_IN: begin
                                acc_d = IO;
                                z_d   = (IO == '0);
                            end
                            SYS_OUT:  oreg_d = acc_q;
`ifdef RISCY_HALT_EN
                            SYS_HALT: state_d = HALTED;
`endif
                            default: ;
                        endcase
                    end
                    OP_LD: begin
                        acc_d = mem;
                        z_d   = (mem == '0);
                    end
                    OP_ST:  ram_we = 1'b1;
                    OP_ADD: begin
                        {c_d, acc_d} = sum;
                        z_d          = (sum[DATA_W-1:0] == '0);
                    end
                    OP_SUB: begin
                        {c_d, acc_d} = diff;
                        z_d          = (diff[DATA_W-1:0] == '0);
                    end
                    OP_AND: begin
                        acc_d = acc_q & mem;
                        z_d   = ((acc_q & mem) == '0);
                    end
                    OP_JMP: pc_d = operand;
                    OP_JZ:  if (z_q) pc_d = operand;
                    default: ;
                endcase
            end
            HALTED: state_d = HALTED;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            acc_q   <= '0;
            oreg_q  <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            oreg_q  <= oreg_d;
            c_q     <= c_d;
            z_q     <= z_d;
        end
    end

    // No reset: RAM contents survive reset; an aborted ST never asserts ram_we.
    always_ff @(posedge CLK) begin
        if (ram_we) ram[operand] <= acc_q;
    end
endmodule

// File: tb/tb_riscy_cpu.sv
// Scoreboard bench for riscy_cpu: an instruction-level model predicts the
// architectural state after every instruction; a monitor checks each EXEC edge.
module tb_riscy_cpu;
    import riscy_pkg::*;

`ifdef RISCY_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    wire  [7:0] IO;
    logic [7:0] in_val = 8'h00;

    riscy_cpu dut (.CLK(CLK), .RST(RST), .IO(IO));

    assign IO = dut.PORT_RD ? in_val : 8'hzz;

    always #5 CLK = ~CLK;

    typedef struct {
        int pc;
        int acc;
        int c;
        int z;
        int io;
        int prd;
    } exp_t;

    exp_t exp_q[$];
    int   total  = 0;
    int   passed = 0;

    logic [7:0] prog [32];
    int m_pc, m_acc, m_c, m_z, m_oreg, m_halted;
    int m_ram [32];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [7:0] enc(input int op, input int a);
        logic [7:0] r;
        r = 8'((op << 5) | (a & 31));
        return r;
    endfunction

    // Instruction-set interpreter: executes n instructions from reset.
    task automatic model_run(input int n);
        int ir, op, a, t;
        exp_t e;
        m_pc = 0; m_acc = 0; m_c = 0; m_z = 0; m_oreg = 0; m_halted = 0;
        for (int k = 0; k < n && !m_halted; k++) begin
            ir = int'(prog[m_pc]);
            m_pc = (m_pc + 1) % 32;
            op = ir / 32;
            a  = ir % 32;
            e.prd = 0;
            case (op)
                0: begin
                    if (a == 1) begin
                        e.prd = 1; m_acc = int'(in_val); m_z = (m_acc == 0);
                    end else if (a == 2) m_oreg = m_acc;
                    else if (a == 31 && HALT_EN) m_halted = 1;
                end
                1: begin m_acc = m_ram[a]; m_z = (m_acc == 0); end
                2: m_ram[a] = m_acc;
                3: begin
                    t = m_acc + m_ram[a];
                    m_c = (t > 255); m_acc = t % 256; m_z = (m_acc == 0);
                end
                4: begin
                    m_c = (m_acc < m_ram[a]);
                    m_acc = (m_acc - m_ram[a] + 256) % 256; m_z = (m_acc == 0);
                end
                5: begin m_acc = m_acc & m_ram[a]; m_z = (m_acc == 0); end
                6: m_pc = a;
                default: if (m_z) m_pc = a;
            endcase
            e.pc = m_pc; e.acc = m_acc; e.c = m_c; e.z = m_z; e.io = m_oreg;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: compares the state right after each edge that ends an EXEC cycle.
    logic prev_exec = 1'b0;
    int   prd_seen  = 0;
    always @(negedge CLK) begin
        exp_t e;
        if (!RST) begin
            prev_exec = 1'b0;
        end else begin
            if (prev_exec) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_instr", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pc",      int'(dut.pc_q),  e.pc);
                    chk("acc",     int'(dut.acc_q), e.acc);
                    chk("carry",   int'(dut.c_q),   e.c);
                    chk("zero",    int'(dut.z_q),   e.z);
                    chk("io",      int'(IO),        e.io);
                    chk("port_rd", prd_seen,        e.prd);
                end
            end
            prev_exec = (dut.state_q == EXEC);
            prd_seen  = int'(dut.PORT_RD);
        end
    end

    // Entered just after a negedge; asserts reset at once (possibly mid-EXEC).
    task automatic run_prog(input int cycles);
        RST = 1'b0;
        #1;
        chk("rst_state",   int'(dut.state_q), int'(FETCH));
        chk("rst_pc",      int'(dut.pc_q),    0);
        chk("rst_acc",     int'(dut.acc_q),   0);
        chk("rst_io",      int'(IO),          0);
        chk("rst_port_rd", int'(dut.PORT_RD), 0);
        chk("drain",       exp_q.size(),      0);
        exp_q.delete();
        for (int i = 0; i < 32; i++) dut.ROM32.memory[i] = prog[i];
        model_run(cycles / 2);
        repeat (5) @(negedge CLK);
        #1 RST = 1'b1;
        repeat (cycles) @(posedge CLK);
        @(negedge CLK);
        #1;
        if (m_halted != 0) begin
            chk("halt_pc", int'(dut.pc_q), m_pc);
            chk("halt_io", int'(IO),       m_oreg);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 32; i++) prog[i] = 8'h00;
    endtask

    initial begin
        int r, cyc;
        @(negedge CLK);
        #1;

        // Fill every RAM word so later reads are defined.
        for (int i = 0; i < 32; i++) prog[i] = enc(2, i);
        run_prog(64);

        clear_prog();
        in_val = 8'h55;
        prog[0] = enc(0, 1); prog[1] = enc(0, 2);
        run_prog(8);

        clear_prog();
        prog[0] = enc(0, 1); prog[1] = enc(2, 3); prog[2] = enc(3, 3);
        prog[3] = enc(3, 3); prog[4] = enc(4, 3);
        run_prog(10);

        clear_prog();
        prog[0] = enc(0, 1); prog[1] = enc(2, 4); prog[2] = enc(4, 4);
        prog[3] = enc(7, 10); prog[4] = enc(0, 2); prog[10] = enc(1, 3);
        run_prog(12);

        clear_prog();
        prog[0] = enc(0, 1); prog[1] = enc(7, 10); prog[2] = enc(0, 2);
        run_prog(8);

        clear_prog();
        run_prog(70);

        clear_prog();
        prog[0] = enc(0, 1); prog[1] = enc(0, 2); prog[2] = enc(0, 31);
        run_prog(20);

        for (int n = 0; n < 25; n++) begin
            in_val = 8'($urandom_range(0, 255));
            for (int i = 0; i < 32; i++) begin
                r = int'($urandom_range(0, 3));
                if (r == 0) begin
                    case ($urandom_range(0, 3))
                        0: prog[i] = enc(0, 0);
                        1: prog[i] = enc(0, 1);
                        2: prog[i] = enc(0, 2);
                        default: prog[i] = enc(0, 31);
                    endcase
                end else begin
                    prog[i] = 8'($urandom_range(32, 255));
                end
            end
            cyc = int'($urandom_range(9, 90));
            run_prog(cyc);
        end

        RST = 1'b0;
        #1;
        chk("final_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
